// File: rtl/modbus_pkg.sv
// modbus_pkg: shared definitions for the Modbus RTU receive path.
//   rx_state_e    receiver FSM state encoding
//   MODBUS_FAST_BAUD / FAST_T15_US / FAST_T35_US
//                 above MODBUS_FAST_BAUD the inter-character and inter-frame
//                 gaps are fixed times instead of character multiples
//   gap_clocks()  converts a gap (in half characters, or fixed us) to clocks
package modbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   localparam int MODBUS_FAST_BAUD = 19200;
   localparam int FAST_T15_US      = 750;
   localparam int FAST_T35_US      = 1750;

   // half_chars is 3 for the 1.5-character gap and 7 for the 3.5-character gap.
   function automatic int gap_clocks(input int clk_freq, input int baud_rate,
                                     input int char_bits, input int half_chars,
                                     input int fast_us);
      if (baud_rate <= MODBUS_FAST_BAUD)
         return half_chars * char_bits * (clk_freq / baud_rate) / 2;
      return clk_freq / 1_000_000 * fast_us;
   endfunction

endpackage

// File: rtl/modbus_uart_rx_if.sv
// modbus_uart_rx_if: serial line in, received bytes and gap events out.
//   rx_pin          serial input, idle high
//   rx_data         last good byte
//   rx_done         1-cycle pulse, rx_data updated
//   rx_drop_frame   1-cycle pulse, 1.5-character idle gap reached
//   rx_new_frame    1-cycle pulse, 3.5-character idle gap reached
//   rx_frame_err    1-cycle pulse, bad stop bit (or bad parity)
//   rx_busy         character reception in progress
// slave  = the receiver, master = the line driver / frame parser side.
interface modbus_uart_rx_if;

   logic       rx_pin;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_drop_frame;
   logic       rx_new_frame;
   logic       rx_frame_err;
   logic       rx_busy;

   modport slave (
      input  rx_pin,
      output rx_data, rx_done, rx_drop_frame, rx_new_frame, rx_frame_err, rx_busy
   );

   modport master (
      output rx_pin,
      input  rx_data, rx_done, rx_drop_frame, rx_new_frame, rx_frame_err, rx_busy
   );

endinterface

// File: rtl/modbus_gap_timer.sv
// modbus_gap_timer: idle-line timer for Modbus RTU framing.
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   clear_i           restart the gap at 0 (end of a character)
//   run_i             count this clock (line idle)
//   drop_o            1-cycle pulse when the gap reaches T15
//   new_o             1-cycle pulse when the gap reaches T35
//   sat_o             gap has reached T35 and stopped counting
// Reset loads the saturated value, so no pulse follows reset.
module modbus_gap_timer #(
   parameter int T15 = 85932,
   parameter int T35 = 200508
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic clear_i,
   input  logic run_i,
   output logic drop_o,
   output logic new_o,
   output logic sat_o
);

   localparam int GAP_W = $clog2(T35 + 1);

   logic [GAP_W-1:0] gap_q, gap_d;
   logic             drop_q, new_q;

   // NOTE: gap_d takes its hold value first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      gap_d = gap_q;
      if (clear_i)
         gap_d = '0;
      else if (run_i && (gap_q < GAP_W'(T35)))
         gap_d = gap_q + GAP_W'(1);
   end

   // Pulses fire only on the step into the threshold, so each fires once per gap.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         gap_q  <= GAP_W'(T35);
         drop_q <= 1'b0;
         new_q  <= 1'b0;
      end else begin
         gap_q  <= gap_d;
         drop_q <= (gap_d != gap_q) && (gap_d == GAP_W'(T15));
         new_q  <= (gap_d != gap_q) && (gap_d == GAP_W'(T35));
      end
   end

   assign drop_o = drop_q;
   assign new_o  = new_q;
   assign sat_o  = (gap_q == GAP_W'(T35));

endmodule

// File: rtl/modbus_uart_rx.sv
// modbus_uart_rx: Modbus RTU UART receiver, 8N1 LSB first.
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   rx_if (slave)     rx_pin in; rx_data, rx_done, rx_drop_frame,
//                     rx_new_frame, rx_frame_err, rx_busy out
// Build option MODBUS_RX_PARITY_EN: adds an even parity bit (8E1); a parity
// mismatch reports rx_frame_err instead of rx_done.
module modbus_uart_rx
   import modbus_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int CHAR_BITS = 11
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   modbus_uart_rx_if.slave   rx_if
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CNT_W    = $clog2(BAUD_DIV);
   localparam int T15      = gap_clocks(CLK_FREQ, BAUD_RATE, CHAR_BITS, 3, FAST_T15_US);
   localparam int T35      = gap_clocks(CLK_FREQ, BAUD_RATE, CHAR_BITS, 7, FAST_T35_US);

   rx_state_e        state_q;
   logic             sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_q;
   logic             done_q, err_q, busy_q;
   logic             fall, bit_tick, stop_sample, stop_ok;
   logic             gap_sat, gap_drop, gap_new;

   assign fall        = prev_q & ~sync2_q;
   assign bit_tick    = (cnt_q == CNT_W'(BAUD_DIV - 1));
   assign stop_sample = (state_q == ST_STOP) && bit_tick;

`ifdef MODBUS_RX_PARITY_EN
   logic par_err_q;
   assign stop_ok = sync2_q & ~par_err_q;
`else
   assign stop_ok = sync2_q;
`endif

   // NOTE: all state updates use <= so every register sees the values from
   // before this edge, independent of statement order.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         // The synchronizer resets to the idle level so release is not a start bit.
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
`ifdef MODBUS_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         sync1_q <= rx_if.rx_pin;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
                  cnt_q <= '0;
                  if (!sync2_q) begin
                     state_q   <= ST_DATA;
                     bit_idx_q <= '0;
                  end else begin
                     // Line back high at mid-bit: a glitch, drop it silently.
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  cnt_q     <= '0;
                  shift_q   <= {sync2_q, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7)
`ifdef MODBUS_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef MODBUS_RX_PARITY_EN
            ST_PARITY: begin
               if (bit_tick) begin
                  cnt_q     <= '0;
                  par_err_q <= (^shift_q) ^ sync2_q;
                  state_q   <= ST_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            ST_STOP: begin
               // Leave at mid stop bit so a back-to-back start edge is caught.
               if (bit_tick) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  if (stop_ok) begin
                     data_q <= shift_q;
                     done_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   modbus_gap_timer #(
      .T15 (T15),
      .T35 (T35)
   ) u_gap_timer (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .clear_i  (stop_sample),
      .run_i    ((state_q == ST_IDLE) && !gap_sat),
      .drop_o   (gap_drop),
      .new_o    (gap_new),
      .sat_o    (gap_sat)
   );

   assign rx_if.rx_data       = data_q;
   assign rx_if.rx_done       = done_q;
   assign rx_if.rx_frame_err  = err_q;
   assign rx_if.rx_busy       = busy_q;
   assign rx_if.rx_drop_frame = gap_drop;
   assign rx_if.rx_new_frame  = gap_new;

endmodule

// File: tb/tb_modbus_uart_rx.sv
// tb_modbus_uart_rx: scoreboard bench for modbus_uart_rx.
// Runs at a scaled clock (96 kHz, 9600 baud) so one bit is 10 clocks,
// 1.5T is 165 clocks and 3.5T is 385 clocks.
module tb_modbus_uart_rx;

   localparam int CLK_FREQ  = 96_000;
   localparam int BAUD_RATE = 9600;
   localparam int BIT_CLKS  = 10;               // 96000 / 9600
   localparam int EXP_T15   = 165;              // 3 * 11 * 10 / 2
   localparam int EXP_T35   = 385;              // 7 * 11 * 10 / 2
   localparam int EXP_BUSY  = 95;               // 9.5 bit times
   localparam int IDLE_WAIT = EXP_T35 + 40;

   typedef enum logic {EV_DONE, EV_ERR} ev_kind_e;
   typedef struct {
      ev_kind_e   kind;
      logic [7:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   modbus_uart_rx_if rx_if ();

   modbus_uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .CHAR_BITS (11)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .rx_if    (rx_if)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_errors = 0;
   ev_t sb[$];
   ev_t ev;
   int  cyc = 0;
   int  last_evt_cyc = 0;
   int  drop_cnt = 0;
   int  new_cnt = 0;
   int  busy_len = 0;
   int  last_busy = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      rx_if.rx_pin = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_if.rx_pin = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx_if.rx_pin = stop_bit;
      repeat (BIT_CLKS) @(negedge clk);
      rx_if.rx_pin = 1'b1;
   endtask

   task automatic expect_evt(input ev_kind_e k, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      sb.push_back(e);
   endtask

   // Output monitor: samples on the falling edge, pops the scoreboard on each
   // character event and times the gap pulses against the last character.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (rx_if.rx_done || rx_if.rx_frame_err) begin
            if (sb.size() == 0) begin
               check("unexpected_evt", int'({rx_if.rx_done, rx_if.rx_frame_err}), 0);
            end else begin
               ev = sb.pop_front();
               check("evt_done", int'(rx_if.rx_done), int'(ev.kind == EV_DONE));
               check("evt_err", int'(rx_if.rx_frame_err), int'(ev.kind == EV_ERR));
               check("rx_data", int'(rx_if.rx_data), int'(ev.data));
            end
            last_evt_cyc = cyc;
         end
         if (rx_if.rx_drop_frame) begin
            drop_cnt++;
            check("drop_delay", cyc - last_evt_cyc, EXP_T15);
         end
         if (rx_if.rx_new_frame) begin
            new_cnt++;
            check("new_delay", cyc - last_evt_cyc, EXP_T35);
         end
         if (rx_if.rx_busy) begin
            busy_len++;
         end else if (busy_len != 0) begin
            last_busy = busy_len;
            busy_len  = 0;
         end
      end
   end

   initial begin
      logic [7:0] frame [8];
      frame = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};

      rst_n        = 1'b0;
      rx_if.rx_pin = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_data", int'(rx_if.rx_data), 0);
      check("rst_done", int'(rx_if.rx_done), 0);
      check("rst_drop", int'(rx_if.rx_drop_frame), 0);
      check("rst_new", int'(rx_if.rx_new_frame), 0);
      check("rst_err", int'(rx_if.rx_frame_err), 0);
      check("rst_busy", int'(rx_if.rx_busy), 0);
      rst_n = 1'b1;
      repeat (IDLE_WAIT) @(negedge clk);
      check("post_rst_drop_cnt", drop_cnt, 0);
      check("post_rst_new_cnt", new_cnt, 0);

      // Single byte: data, busy length, one of each gap pulse.
      expect_evt(EV_DONE, 8'hA5);
      send_byte(8'hA5, 1'b1);
      repeat (IDLE_WAIT) @(negedge clk);
      check("a5_busy_len", last_busy, EXP_BUSY);
      check("a5_drop_cnt", drop_cnt, 1);
      check("a5_new_cnt", new_cnt, 1);
      check("a5_sb_empty", sb.size(), 0);

      // Single byte then a long idle: no repeated gap pulses.
      expect_evt(EV_DONE, 8'h01);
      send_byte(8'h01, 1'b1);
      repeat (2 * IDLE_WAIT) @(negedge clk);
      check("b01_drop_cnt", drop_cnt, 2);
      check("b01_new_cnt", new_cnt, 2);
      check("b01_sb_empty", sb.size(), 0);

      // Back-to-back frame: no drop between characters, one pair at the end.
      for (int i = 0; i < 8; i++) begin
         expect_evt(EV_DONE, frame[i]);
         send_byte(frame[i], 1'b1);
      end
      check("frame_no_mid_drop", drop_cnt, 2);
      repeat (IDLE_WAIT) @(negedge clk);
      check("frame_drop_cnt", drop_cnt, 3);
      check("frame_new_cnt", new_cnt, 3);
      check("frame_sb_empty", sb.size(), 0);

      // Short low glitch on the idle line: rejected at mid start bit.
      rx_if.rx_pin = 1'b0;
      repeat (2) @(negedge clk);
      rx_if.rx_pin = 1'b1;
      repeat (IDLE_WAIT) @(negedge clk);
      check("glitch_busy_len", last_busy, BIT_CLKS / 2);
      check("glitch_drop_cnt", drop_cnt, 3);
      check("glitch_new_cnt", new_cnt, 3);
      check("glitch_data", int'(rx_if.rx_data), 32'h0B);

      // Low stop bit: frame error, data held, gap timed from the error.
      expect_evt(EV_ERR, 8'h0B);
      send_byte(8'h3C, 1'b0);
      repeat (IDLE_WAIT) @(negedge clk);
      check("ferr_drop_cnt", drop_cnt, 4);
      check("ferr_new_cnt", new_cnt, 4);
      check("ferr_sb_empty", sb.size(), 0);

      // Reset in the middle of a character.
      rx_if.rx_pin = 1'b0;
      repeat (BIT_CLKS * 3 + 5) @(negedge clk);
      check("mid_busy", int'(rx_if.rx_busy), 1);
      rst_n        = 1'b0;
      rx_if.rx_pin = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_data", int'(rx_if.rx_data), 0);
      check("mid_rst_busy", int'(rx_if.rx_busy), 0);
      check("mid_rst_done", int'(rx_if.rx_done), 0);
      rst_n = 1'b1;
      repeat (IDLE_WAIT) @(negedge clk);
      check("mid_rst_drop_cnt", drop_cnt, 4);
      check("mid_rst_new_cnt", new_cnt, 4);

      // Receiver recovers after the mid-byte reset.
      expect_evt(EV_DONE, 8'h55);
      send_byte(8'h55, 1'b1);
      repeat (IDLE_WAIT) @(negedge clk);
      check("recover_drop_cnt", drop_cnt, 5);
      check("recover_new_cnt", new_cnt, 5);
      check("recover_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
